// File: rtl/axis_s_rx.sv
// rtl/axis_s_rx.sv - AXI-Stream slave receiver: show-ahead FIFO plus packet framing FSM.
// Optional statistics counters are built when AXIS_S_RX_STATS_EN is defined.
module axis_s_rx #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              tvalid,
    output logic              tready,
    input  logic [DATA_W-1:0] tdata,
    input  logic              tlast,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic [ADDR_W:0]   level,
    output logic              in_pkt,
    output logic              received,
    output logic [31:0]       pkt_count,
    output logic [31:0]       beat_count
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    logic [DATA_W:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   level_q;
    logic              received_q;
    state_t            state_q;
    state_t            state_d;
    logic              full;
    logic              accept;
    logic              pop;
    logic [DATA_W:0]   head;

    // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
    assign full     = (level_q == FULL_LEVEL);
    assign tready   = ~areset & ~full;
    assign rd_valid = ~areset & (level_q != '0);
    assign accept   = tvalid & tready;
    assign pop      = rd_en & rd_valid;

    assign head     = mem[rd_ptr_q];
    assign rd_data  = head[DATA_W-1:0];
    assign rd_last  = head[DATA_W];
    assign level    = level_q;
    assign in_pkt   = (state_q == ST_RECV);
    assign received = received_q;

    always_ff @(posedge aclk) begin
        if (accept) begin
            mem[wr_ptr_q] <= {tlast, tdata};
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            received_q <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            received_q <= accept & tlast;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && !tlast) state_d = ST_RECV;
            ST_RECV: if (accept && tlast)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef AXIS_S_RX_STATS_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] beat_cnt_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else if (accept) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (tlast) begin
                pkt_cnt_q <= pkt_cnt_q + 1'b1;
            end
        end
    end

    assign pkt_count  = pkt_cnt_q;
    assign beat_count = beat_cnt_q;
`else
    assign pkt_count  = '0;
    assign beat_count = '0;
`endif

endmodule

// File: tb/tb_axis_s_rx.sv
// tb/tb_axis_s_rx.sv - directed self-checking bench for axis_s_rx.
module tb_axis_s_rx;

    logic        aclk;
    logic        areset;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        tlast;
    logic        rd_en;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic [3:0]  level;
    logic        in_pkt;
    logic        received;
    logic [31:0] pkt_count;
    logic [31:0] beat_count;

    int errors = 0;
    int checks = 0;

    axis_s_rx #(.DATA_W(32), .DEPTH(8)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .tvalid     (tvalid),
        .tready     (tready),
        .tdata      (tdata),
        .tlast      (tlast),
        .rd_en      (rd_en),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .level      (level),
        .in_pkt     (in_pkt),
        .received   (received),
        .pkt_count  (pkt_count),
        .beat_count (beat_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        areset = 1'b1;
        tvalid = 1'b1;
        tdata  = 32'hDEAD_BEEF;
        tlast  = 1'b0;
        rd_en  = 1'b0;

        // T1 reset held with tvalid high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_tready_in_reset", 64'(tready), 64'd0);
            check("t1_rd_valid_in_reset", 64'(rd_valid), 64'd0);
        end
        check("t1_level", 64'(level), 64'd0);
        tvalid = 1'b0;
        areset = 1'b0;
        #1;
        check("t1_tready_release", 64'(tready), 64'd1);
        check("t1_rd_valid_release", 64'(rd_valid), 64'd0);

        // T2 single-beat packet
        send(32'hA5A5_0001, 1'b1);
        check("t2_received", 64'(received), 64'd1);
        check("t2_rd_valid", 64'(rd_valid), 64'd1);
        check("t2_rd_data", 64'(rd_data), 64'hA5A5_0001);
        check("t2_rd_last", 64'(rd_last), 64'd1);
        check("t2_level", 64'(level), 64'd1);
        check("t2_in_pkt", 64'(in_pkt), 64'd0);
        tick();
        check("t2_received_pulse_end", 64'(received), 64'd0);
        pop_one();
        check("t2_level_after_pop", 64'(level), 64'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t2_empty_pop_ignored", 64'(level), 64'd0);

        // T3 fill to full, pop one, write into the wrapped slot
        for (int i = 0; i < 8; i++) begin
            send(32'(i), (i == 7));
        end
        check("t3_level_full", 64'(level), 64'd8);
        check("t3_tready_full", 64'(tready), 64'd0);
        check("t3_received_last", 64'(received), 64'd1);
        check("t3_head", 64'(rd_data), 64'd0);
        rd_en  = 1'b1;
        tvalid = 1'b1;
        tdata  = 32'd8;
        tlast  = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t3_no_write_when_full", 64'(level), 64'd7);
        check("t3_tready_after_pop", 64'(tready), 64'd1);
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
        check("t3_level_refull", 64'(level), 64'd8);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("t3_order_%0d", i), 64'(rd_data), 64'(i));
            pop_one();
        end
        check("t3_level_drained", 64'(level), 64'd0);

        // T4 streaming at constant level 3
        send(32'd100, 1'b0);
        send(32'd101, 1'b0);
        send(32'd102, 1'b0);
        check("t4_prefill_level", 64'(level), 64'd3);
        check("t4_in_pkt", 64'(in_pkt), 64'd1);
        rd_en  = 1'b1;
        tvalid = 1'b1;
        tlast  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tdata = 32'(103 + k);
            check($sformatf("t4_head_%0d", k), 64'(rd_data), 64'(100 + k));
            tick();
            check($sformatf("t4_level_%0d", k), 64'(level), 64'd3);
        end
        tvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t4_tail_%0d", k), 64'(rd_data), 64'(120 + k));
            tick();
        end
        rd_en = 1'b0;
        check("t4_level_end", 64'(level), 64'd0);

        // T5 reset mid-packet
        send(32'h1111_0000, 1'b0);
        send(32'h1111_0001, 1'b0);
        check("t5_in_pkt_before", 64'(in_pkt), 64'd1);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check("t5_level", 64'(level), 64'd0);
        check("t5_in_pkt", 64'(in_pkt), 64'd0);
        check("t5_received", 64'(received), 64'd0);
        check("t5_rd_valid", 64'(rd_valid), 64'd0);
        send(32'h55, 1'b0);
        check("t5_fresh_in_pkt", 64'(in_pkt), 64'd1);
        check("t5_fresh_no_recv", 64'(received), 64'd0);
        send(32'h66, 1'b1);
        check("t5_fresh_received", 64'(received), 64'd1);
        check("t5_fresh_in_pkt_done", 64'(in_pkt), 64'd0);
        check("t5_fresh_level", 64'(level), 64'd2);
        check("t5_fresh_head", 64'(rd_data), 64'h55);
        pop_one();
        check("t5_fresh_second", 64'(rd_data), 64'h66);
        check("t5_fresh_second_last", 64'(rd_last), 64'd1);
        pop_one();

`ifdef AXIS_S_RX_STATS_EN
        // T6 statistics counters
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check("t6_pkt_reset", 64'(pkt_count), 64'd0);
        send(32'd1, 1'b1);
        send(32'd2, 1'b0);
        send(32'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(32'(10 + i), (i == 4));
        end
        check("t6_pkt_count", 64'(pkt_count), 64'd3);
        check("t6_beat_count", 64'(beat_count), 64'd8);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        force dut.beat_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.beat_cnt_q;
        check("t6_beat_preload", 64'(beat_count), 64'hFFFF_FFFF);
        send(32'd7, 1'b0);
        check("t6_beat_wrap", 64'(beat_count), 64'd0);
`else
        send(32'd7, 1'b1);
        check("t6_pkt_tied", 64'(pkt_count), 64'd0);
        check("t6_beat_tied", 64'(beat_count), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
